pipe_adder: RTL and testbench

Parametrised, pipelined unsigned adder with valid/ready handshakes on both sides. It generalises the single-bit combinational adder to WIDTH-bit operands, a configurable pipeline depth, full backpressure and synchronous flush. It sits between a stimulus producer (testbench or upstream datapath) and a result consumer, and carries an opaque tag alongside each sum so results can be matched to requests.

---
 rtl/pipe_adder.sv | 108 ++++++++++
 tb/tb_pipe_adder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit unsigned adder with valid/ready on both sides, flush and a pass-through tag.
// Define PIPE_ADDER_SAT_EN to saturate ans to all ones on carry-out (carry still reports the true carry).
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             carry,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] ans;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [STAGES:0]   room;
  logic [WIDTH:0]    sum;
  entry_t            new_entry;
  entry_t            stage_q [STAGES];

  assign sum = {1'b0, operand1} + {1'b0, operand2};

  always_comb begin
    new_entry       = '0;
    new_entry.carry = sum[WIDTH];
    new_entry.tag   = in_tag;
`ifdef PIPE_ADDER_SAT_EN
    new_entry.ans   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    new_entry.ans   = sum[WIDTH-1:0];
`endif
  end

  // room[k]: stage k can take a new entry this cycle, i.e. it is empty or
  // the stall chain from the output is broken somewhere at or below it.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no path leaves it unassigned (no latch).
    room         = '0;
    room[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      room[k] = !v[k] || room[k+1];
    end
  end

  assign adv      = v & room[STAGES:1];
  assign in_ready = room[0];

  always_comb begin
    load    = '0;
    load[0] = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (!rst_n) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v[k] <= 1'b1;
        end else if (adv[k]) begin
          v[k] <= 1'b0;
        end
      end
    end
  end

  // NOTE: payload registers carry no reset; they are only ever observed when qualified by a valid bit.
  always_ff @(posedge clk) begin
    if (load[0]) begin
      stage_q[0] <= new_entry;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign ans       = stage_q[STAGES-1].ans;
  assign carry     = stage_q[STAGES-1].carry;
  assign out_tag   = stage_q[STAGES-1].tag;
  assign busy      = |v;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (WIDTH=8, STAGES=2, TAG_W=4), plus a
// deterministic handshake-toggling run checked against an in-order scoreboard.
module tb_pipe_adder;

`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [3:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ans;
  logic       carry;
  logic [3:0] out_tag;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] ans;
    logic       c;
    logic [3:0] tag;
  } exp_t;

  exp_t q[$];

  pipe_adder #(.WIDTH(8), .STAGES(2), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand1  (operand1),
    .operand2  (operand2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ans       (ans),
    .carry     (carry),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
    logic [8:0] s;
    exp_t e;
    s     = {1'b0, a} + {1'b0, b};
    e.c   = s[8];
    e.ans = (SAT && s[8]) ? 8'hFF : s[7:0];
    e.tag = t;
    return e;
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
    in_valid = 1'b1;
    operand1 = a;
    operand2 = b;
    in_tag   = t;
  endtask

  task automatic expect_out(input string name, input logic [7:0] ea, input logic ec, input logic [3:0] et);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_ans"},   32'(ans),       32'(ea));
    check({name, "_carry"}, 32'(carry),     32'(ec));
    check({name, "_tag"},   32'(out_tag),   32'(et));
  endtask

  // One isolated transaction with out_ready high: result appears after two edges.
  task automatic send_one(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] t, input logic [7:0] ea, input logic ec);
    drive(a, b, t);
    tick();
    in_valid = 1'b0;
    check({name, "_lat"}, 32'(out_valid), 32'd0);
    tick();
    expect_out(name, ea, ec, t);
    tick();
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (q.size() == 0) begin
      check({name, "_spurious"}, 32'(out_valid), 32'd0);
    end else begin
      e = q.pop_front();
      check({name, "_ans"},   32'(ans),     32'(e.ans));
      check({name, "_carry"}, 32'(carry),   32'(e.c));
      check({name, "_tag"},   32'(out_tag), 32'(e.tag));
    end
  endtask

  initial begin
    int acc;
    int sent;
    int got;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    operand1  = '0;
    operand2  = '0;
    in_tag    = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Back-to-back pair with out_ready held high.
    drive(8'd3, 8'd4, 4'd1);
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("b2b_lat0", 32'(out_valid), 32'd0);
    drive(8'd200, 8'd100, 4'd2);
    tick();
    in_valid = 1'b0;
    expect_out("b2b_first", 8'd7, 1'b0, 4'd1);
    tick();
    expect_out("b2b_second", SAT ? 8'd255 : 8'd44, 1'b1, 4'd2);
    tick();
    check("b2b_empty_valid", 32'(out_valid), 32'd0);
    check("b2b_empty_busy",  32'(busy),      32'd0);

    // Boundary operands.
    send_one("bnd_zero",   8'd0,   8'd0,   4'd3, 8'd0,                  1'b0);
    send_one("bnd_wrap",   8'd255, 8'd1,   4'd4, SAT ? 8'd255 : 8'd0,   1'b1);
    send_one("bnd_max",    8'd255, 8'd255, 4'd5, SAT ? 8'd255 : 8'd254, 1'b1);
    send_one("bnd_nocarry",8'd128, 8'd127, 4'd6, 8'd255,                1'b0);

    // Backpressure: only STAGES requests accepted while out_ready is low.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      drive(8'(10 + i), 8'(20 + i), 4'(8 + i));
      #1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("bp_accepts",  32'(acc),      32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_busy",     32'(busy),     32'd1);
    expect_out("bp_hold0", 8'd30, 1'b0, 4'd8);
    tick();
    expect_out("bp_hold1", 8'd30, 1'b0, 4'd8);
    out_ready = 1'b1;
    #1;
    check("bp_full_in_ready", 32'(in_ready), 32'd1);
    tick();
    expect_out("bp_res1", 8'd32, 1'b0, 4'd9);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);
    drive(8'd12, 8'd22, 4'd10);
    tick();
    drive(8'd13, 8'd23, 4'd11);
    tick();
    in_valid = 1'b0;
    expect_out("bp_res2", 8'd34, 1'b0, 4'd10);
    tick();
    expect_out("bp_res3", 8'd36, 1'b0, 4'd11);
    tick();
    check("bp_end_busy", 32'(busy), 32'd0);

    // Full pipeline with simultaneous accept and release keeps occupancy.
    out_ready = 1'b0;
    drive(8'd1, 8'd1, 4'd1);
    tick();
    drive(8'd2, 8'd2, 4'd2);
    tick();
    out_ready = 1'b1;
    drive(8'd3, 8'd3, 4'd3);
    #1;
    check("sim_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("sim_busy_full", 32'(in_ready), 32'd0);
    expect_out("sim_next", 8'd4, 1'b0, 4'd2);
    out_ready = 1'b1;
    tick();
    expect_out("sim_last", 8'd6, 1'b0, 4'd3);
    tick();

    // Flush with two entries in flight and a concurrent accepted input.
    out_ready = 1'b0;
    drive(8'd1, 8'd2, 4'd1);
    tick();
    drive(8'd3, 8'd4, 4'd2);
    tick();
    out_ready = 1'b1;
    flush = 1'b1;
    drive(8'd50, 8'd50, 4'd7);
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_busy",      32'(busy),      32'd0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_stale", 32'(out_valid), 32'd0);
    end
    send_one("fl_after", 8'd40, 8'd2, 4'd9, 8'd42, 1'b0);

    // Asynchronous reset mid-stream, away from any rising edge.
    out_ready = 1'b0;
    drive(8'd9, 8'd9, 4'd1);
    tick();
    drive(8'd8, 8'd8, 4'd2);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_busy",      32'(busy),      32'd0);
    check("ar_in_ready",  32'(in_ready),  32'd1);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send_one("ar_after", 8'd100, 8'd27, 4'd3, 8'd127, 1'b0);

    // Deterministic in_valid/out_ready toggling against an in-order scoreboard.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && (sent < 60 || q.size() != 0); cyc++) begin
      in_valid  = (cyc % 3 != 2) && (sent < 60);
      operand1  = 8'(sent * 37 + 11);
      operand2  = 8'(sent * 91 + 200);
      in_tag    = 4'(sent);
      out_ready = (cyc % 5 < 3);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(model(operand1, operand2, in_tag));
        sent++;
      end
      if (out_valid && out_ready) begin
        pop_check("rnd");
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("rnd_sent",  32'(sent),     32'd60);
    check("rnd_got",   32'(got),      32'd60);
    check("rnd_empty", 32'(q.size()), 32'd0);
    check("rnd_idle",  32'(busy),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
